// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one word read at a time and feeds the IF/ID register.
// Latency: a response is visible on if_*_o one cycle after imem_resp; at most one request in flight.
// Backpressure: stall_i parks a response in a one-entry hold buffer and drops imem_read until decode frees up.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic [6:0]  if_opcode_o,
  output logic [2:0]  if_funct3_o,
  output logic [6:0]  if_funct7_o
);

  typedef enum logic [1:0] {
    START   = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic        consumed;
  logic        out_free;
  logic [31:0] redir_target;
  logic [31:0] pc_plus4;

  assign consumed     = valid_q & ~stall_i;
  assign out_free     = ~valid_q | ~stall_i;
  // Low address bits are ignored so a misaligned target can never reach memory.
  assign redir_target = {redirect_pc_i[31:2], 2'b00};
  // Plain 32-bit add: 0xFFFF_FFFC rolls over to 0.
  assign pc_plus4     = pc_q + 32'd4;

  // State and datapath registers; async active-low reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= START;
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      out_pc_q     <= 32'd0;
      out_instr_q  <= 32'd0;
      hold_pc_q    <= 32'd0;
      hold_instr_q <= 32'd0;
      redir_pc_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

  // Next-state logic; redirect is checked first in every state because it wins over everything.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q & ~consumed;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    redir_pc_d   = redir_pc_q;

    if (redirect_i) begin
      // Flush: the IF/ID register and the hold buffer are dead whatever decode is doing.
      valid_d      = 1'b0;
      hold_pc_d    = 32'd0;
      hold_instr_d = 32'd0;
    end

    unique case (state_q)
      START: begin
        state_d = FETCH;
        if (redirect_i) begin
          pc_d = redir_target;
        end
      end

      FETCH: begin
        if (redirect_i) begin
          if (imem_resp) begin
            // Response lands on the redirect cycle: drop it and refetch immediately.
            pc_d    = redir_target;
            state_d = FETCH;
          end else begin
            // Request still outstanding: keep the address stable and wait it out.
            redir_pc_d = redir_target;
            state_d    = DISCARD;
          end
        end else if (imem_resp) begin
          if (out_free) begin
            valid_d     = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = imem_rdata;
            pc_d        = pc_plus4;
          end else begin
            hold_pc_d    = pc_q;
            hold_instr_d = imem_rdata;
            state_d      = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect_i) begin
          pc_d    = redir_target;
          state_d = FETCH;
        end else if (out_free) begin
          valid_d     = 1'b1;
          out_pc_d    = hold_pc_q;
          out_instr_d = hold_instr_q;
          pc_d        = pc_plus4;
          state_d     = FETCH;
        end
      end

      DISCARD: begin
        if (redirect_i) begin
          // A newer redirect supersedes the buffered one.
          if (imem_resp) begin
            pc_d    = redir_target;
            state_d = FETCH;
          end else begin
            redir_pc_d = redir_target;
          end
        end else if (imem_resp) begin
          pc_d    = redir_pc_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = START;
      end
    endcase
  end

  // Request and IF/ID outputs; the decode fields are pure slices of the held word.
  always_comb begin
    imem_read    = (state_q == FETCH) || (state_q == DISCARD);
    imem_address = pc_q;
    if_valid_o   = valid_q;
    if_pc_o      = out_pc_q;
    if_instr_o   = out_instr_q;
    if_opcode_o  = out_instr_q[6:0];
    if_funct3_o  = out_instr_q[14:12];
    if_funct7_o  = out_instr_q[31:25];
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected IF/ID transfers, a monitor pops them.
// Latency: transfers are checked at the falling edge of the cycle decode consumes them.
// Backpressure: stall_i is driven directly to exercise the hold path.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic [6:0]  if_opcode_o;
  logic [2:0]  if_funct3_o;
  logic [6:0]  if_funct7_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } xfer_t;

  xfer_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  bit    done     = 0;

  fetch_stage #(.RESET_PC(32'h0000_0060)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_read     (imem_read),
    .imem_address  (imem_address),
    .imem_rdata    (imem_rdata),
    .imem_resp     (imem_resp),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o),
    .if_opcode_o   (if_opcode_o),
    .if_funct3_o   (if_funct3_o),
    .if_funct7_o   (if_funct7_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed IF/ID entry must match the oldest expected transfer.
  initial begin
    xfer_t e;
    while (!done) begin
      @(negedge clk);
      if (!done && rst && if_valid_o && !stall_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer_pc", if_pc_o, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check("xfer_pc", if_pc_o, e.pc);
          check("xfer_instr", if_instr_o, e.instr);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; imem_rdata = 32'd0; imem_resp = 1'b0;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    #23;
    check("rst_read", {31'd0, imem_read}, 32'd0);
    check("rst_valid", {31'd0, if_valid_o}, 32'd0);
    check("rst_pc", if_pc_o, 32'd0);
    check("rst_instr", if_instr_o, 32'd0);
    check("rst_addr", imem_address, 32'h60);

    // First fetch at the reset PC, response two cycles later.
    tick(); rst = 1'b1;
    tick();
    check("start_read", {31'd0, imem_read}, 32'd1);
    check("start_addr", imem_address, 32'h60);
    tick();
    imem_resp = 1'b1; imem_rdata = 32'h0000_0013;
    exp_q.push_back('{32'h60, 32'h13});
    tick();
    imem_resp = 1'b0; stall_i = 1'b1;
    check("f1_valid", {31'd0, if_valid_o}, 32'd1);
    check("f1_pc", if_pc_o, 32'h60);
    check("f1_instr", if_instr_o, 32'h13);
    check("f1_next_addr", imem_address, 32'h64);
    check("f1_read", {31'd0, imem_read}, 32'd1);

    // Second response while decode is stalled goes to the hold buffer.
    tick();
    imem_resp = 1'b1; imem_rdata = 32'h0040_0093;
    exp_q.push_back('{32'h64, 32'h0040_0093});
    tick();
    imem_resp = 1'b0;
    check("hold_read", {31'd0, imem_read}, 32'd0);
    check("hold_pc", if_pc_o, 32'h60);
    tick();
    check("hold2_pc", if_pc_o, 32'h60);
    check("hold2_valid", {31'd0, if_valid_o}, 32'd1);
    stall_i = 1'b0;
    tick();
    check("unhold_pc", if_pc_o, 32'h64);
    check("unhold_addr", imem_address, 32'h68);
    check("unhold_read", {31'd0, imem_read}, 32'd1);
    tick();
    check("consumed_valid", {31'd0, if_valid_o}, 32'd0);
    check("consumed_pc_kept", if_pc_o, 32'h64);

    // Redirect with a request outstanding: address held, response discarded.
    redirect_i = 1'b1; redirect_pc_i = 32'h103;
    tick();
    redirect_i = 1'b0;
    check("disc_read", {31'd0, imem_read}, 32'd1);
    check("disc_addr", imem_address, 32'h68);
    check("disc_valid", {31'd0, if_valid_o}, 32'd0);
    tick();
    imem_resp = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_resp = 1'b0;
    check("redir_addr", imem_address, 32'h100);
    check("redir_valid", {31'd0, if_valid_o}, 32'd0);

    // Redirect coinciding with a response: instruction dropped.
    imem_resp = 1'b1; imem_rdata = 32'h1111_1111;
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    tick();
    imem_resp = 1'b0; redirect_i = 1'b0;
    check("same_cyc_valid", {31'd0, if_valid_o}, 32'd0);
    check("same_cyc_addr", imem_address, 32'h200);

    // Misaligned redirect near the top of memory, then wraparound.
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    tick();
    redirect_i = 1'b0;
    imem_resp = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    imem_resp = 1'b0;
    check("top_addr", imem_address, 32'hFFFF_FFFC);
    imem_resp = 1'b1; imem_rdata = 32'h40A3_D0B3;
    exp_q.push_back('{32'hFFFF_FFFC, 32'h40A3_D0B3});
    tick();
    imem_resp = 1'b0;
    check("wrap_pc", if_pc_o, 32'hFFFF_FFFC);
    check("wrap_addr", imem_address, 32'h0);
    check("opcode", {25'd0, if_opcode_o}, 32'h33);
    check("funct3", {29'd0, if_funct3_o}, 32'h5);
    check("funct7", {25'd0, if_funct7_o}, 32'h20);

    // Reach HOLD, then reset asynchronously mid-cycle.
    tick();
    stall_i = 1'b1;
    imem_resp = 1'b1; imem_rdata = 32'h0000_0011;
    tick();
    imem_resp = 1'b0;
    tick();
    imem_resp = 1'b1; imem_rdata = 32'h0000_0022;
    tick();
    imem_resp = 1'b0;
    check("pre_rst_hold_read", {31'd0, imem_read}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", {31'd0, if_valid_o}, 32'd0);
    check("arst_pc", if_pc_o, 32'd0);
    check("arst_instr", if_instr_o, 32'd0);
    check("arst_read", {31'd0, imem_read}, 32'd0);
    check("arst_addr", imem_address, 32'h60);

    // A stray response during reset and START must be ignored.
    stall_i = 1'b0; imem_resp = 1'b1; imem_rdata = 32'h3333_3333;
    tick();
    rst = 1'b1;
    tick();
    imem_resp = 1'b0;
    check("post_rst_valid", {31'd0, if_valid_o}, 32'd0);
    check("post_rst_addr", imem_address, 32'h60);
    check("post_rst_read", {31'd0, imem_read}, 32'd1);
    tick();
    check("post_rst_valid2", {31'd0, if_valid_o}, 32'd0);

    check("sb_empty", exp_q.size(), 32'd0);
    done = 1'b1;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
